seg_stream_tx: RTL and testbench
================================

SEG_STREAM_TX -- requirements
Module: seg_stream_tx

Interface
REQ-001 Parameter TOKEN_W, default 17, meaning stream token width: bit 16 is the control flag, bits 15:0 are payload.
REQ-002 Parameter WORD_W, default 16, meaning input word width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clk_en  in  1  global enable; when low, all state holds
- flush  in  1  synchronous clear to IDLE
- tile_en  in  1  block enable; start condition
- num_segments  in  16  segment count, sampled at start
- stop_lvl  in  8  stop-token level, sampled at start
- word_in  in  16  length-prefixed input words
- word_in_valid  in  1  input valid
- word_in_ready  out  1  input ready
- token_out  out  17  output token stream
- token_out_valid  out  1  output valid
- token_out_ready  in  1  output ready
- done  out  1  high from DONE token acceptance until flush or reset

Function
REQ-010 Input format SHALL be, per segment, a length word L followed by L data words.
REQ-011 Output SHALL be, per segment, L data tokens {1'b0, word} followed by one stop token {1'b1, 8'h00, stop_lvl}, then one DONE token 17'h10100 after the last segment.
REQ-012 FSM states SHALL be IDLE, LEN, DATA, STOP, DONE_TOK, FINISH.
REQ-013 IDLE: when tile_en=1, capture num_segments and stop_lvl, clear seg_cnt, then go to DONE_TOK if num_segments==0, else to LEN.
REQ-014 LEN: accept one word into elem_rem; go to STOP if the word is 0, else to DATA; emit no token.
REQ-015 DATA: each accepted word SHALL emit one data token and decrement elem_rem; go to STOP when elem_rem reaches 0.
REQ-016 STOP: emit the stop token, then increment seg_cnt; go to DONE_TOK if seg_cnt+1==num_segments, else to LEN.
REQ-017 DONE_TOK: emit 17'h10100, then go to FINISH.
REQ-018 FINISH: hold done=1; word_in_ready=0; leave only on flush or reset.
REQ-019 The output SHALL be a single registered slot. slot_free = ~token_out_valid | token_out_ready. Emitting loads the slot; token_out_valid clears when the token is consumed and nothing new is loaded.
REQ-020 word_in_ready SHALL equal (state==LEN) | ((state==DATA) & slot_free); it is combinational from state and token_out_ready.
REQ-021 STOP and DONE_TOK SHALL emit only when slot_free; otherwise they stall in place.
REQ-022 Latency from an accepted data word to token_out_valid SHALL be 1 cycle; full throughput SHALL be 1 token/cycle under ready=1.
REQ-023 token_out SHALL hold stable while valid=1 and ready=0.
REQ-024 A simultaneous consume and load SHALL keep valid=1 and update the data.
REQ-025 Counters: elem_rem and seg_cnt are 16-bit, wrap-free; a length of 16'hFFFF is legal.
REQ-026 A flush mid-stream SHALL discard the slot contents (valid=0), return to IDLE and clear done; remaining input words are not drained.
REQ-027 clk_en=0 SHALL freeze state, counters and the slot; word_in_ready and token_out_valid are forced to 0 while clk_en=0.
REQ-028 Changes to num_segments or stop_lvl after start SHALL have no effect until the next IDLE.

Reset
REQ-030 On rst_n=0 at a clk edge: state=IDLE, token_out_valid=0, token_out=0, done=0, seg_cnt=0, elem_rem=0.
REQ-031 Reset SHALL take priority over flush, and flush over clk_en.
REQ-032 Reset asserted mid-operation SHALL behave identically to REQ-030, with no token emitted on the reset cycle.

Structure
REQ-040 A shared package SHALL hold the FSM state enum, TOKEN_W, the DONE_TOKEN (17'h10100) constant, and a stop-token build function.
REQ-041 One sub-module, stream_out_reg, SHALL implement the single-slot ready/valid output register; the FSM and counters stay in seg_stream_tx.

Verification
REQ-050 num_segments=2, stop_lvl=0, input 3,A,B,C,1,D, ready=1 -> output A,B,C,10000,D,10000,10100; done asserts 1 cycle after the last token is accepted.
REQ-051 num_segments=0 -> single 10100 token; done=1; word_in_ready never high.
REQ-052 num_segments=3, lengths 0,2,0, stop_lvl=1 -> 10001, x, y, 10001, 10001, 10100.
REQ-053 Random token_out_ready (50%) over a 100-word stream -> token sequence identical to the ready=1 run; no drops or duplicates; token_out stable while stalled.
REQ-054 flush asserted during DATA with the slot full and ready=0 -> next cycle valid=0, state IDLE; a re-run then produces the correct full sequence.
REQ-055 clk_en=0 for 5 cycles mid-segment -> no handshake occurs; the stream resumes with the correct next token.

Source files
------------

// File: rtl/seg_stream_tx_pkg.sv
// Shared types and constants for the segmented token stream transmitter:
// FSM state encoding, token geometry and the fixed/derived control tokens.
package seg_stream_tx_pkg;

   localparam int TOKEN_W = 17;
   localparam int WORD_W  = 16;

   localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      STOP,
      DONE_TOK,
      FINISH
   } state_e;

   // Stop token: control flag set, upper payload byte zero, level in the low byte.
   function automatic logic [TOKEN_W-1:0] stop_token(input logic [7:0] lvl);
      return {1'b1, 8'h00, lvl};
   endfunction

endpackage

// File: rtl/seg_stream_tx_if.sv
// Word-in / token-out handshake bundle. The master is the transmitter,
// the slave is whatever feeds words and drains tokens.
interface seg_stream_tx_if #(
   parameter int TOKEN_W = seg_stream_tx_pkg::TOKEN_W,
   parameter int WORD_W  = seg_stream_tx_pkg::WORD_W
);

   logic [WORD_W-1:0]  word_in;
   logic               word_in_valid;
   logic               word_in_ready;
   logic [TOKEN_W-1:0] token_out;
   logic               token_out_valid;
   logic               token_out_ready;

   modport master (
      input  word_in, word_in_valid, token_out_ready,
      output word_in_ready, token_out, token_out_valid
   );

   modport slave (
      output word_in, word_in_valid, token_out_ready,
      input  word_in_ready, token_out, token_out_valid
   );

endinterface

// File: rtl/seg_stream_tx_stream_out_reg.sv
// Single-slot ready/valid output register. A load wins over a consume, so a
// token can be drained and replaced in the same cycle at full throughput.
module stream_out_reg #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             clk_en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             slot_free_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   assign slot_free_o = ~valid_q | ready_i;

   always_comb begin
      // NOTE: next-state values default to the held value first, so every path assigns them and no latch is inferred.
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so all flops sample pre-edge values regardless of statement order.
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clk_en_i) begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q & clk_en_i;

endmodule

// File: rtl/seg_stream_tx.sv
// Segmented stream transmitter: turns length-prefixed word segments into data
// tokens, a stop token per segment and a final DONE token.
module seg_stream_tx #(
   parameter int TOKEN_W = seg_stream_tx_pkg::TOKEN_W,
   parameter int WORD_W  = seg_stream_tx_pkg::WORD_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        flush,
   input  logic        tile_en,
   input  logic [15:0] num_segments,
   input  logic [7:0]  stop_lvl,
   output logic        done,
   seg_stream_tx_if.master bus
);

   import seg_stream_tx_pkg::*;

   state_e             state_q, state_d;
   logic [15:0]        seg_cnt_q, seg_cnt_d;
   logic [15:0]        elem_rem_q, elem_rem_d;
   logic [15:0]        num_seg_q, num_seg_d;
   logic [7:0]         stop_lvl_q, stop_lvl_d;
   logic               done_q, done_d;
   logic               load;
   logic [TOKEN_W-1:0] load_data;
   logic               slot_free;
   logic               tok_valid;
   logic [WORD_W-1:0]  word;

   assign word = bus.word_in;

   always_comb begin
      state_d    = state_q;
      seg_cnt_d  = seg_cnt_q;
      elem_rem_d = elem_rem_q;
      num_seg_d  = num_seg_q;
      stop_lvl_d = stop_lvl_q;
      done_d     = done_q;
      load       = 1'b0;
      load_data  = '0;

      unique case (state_q)
         IDLE: if (tile_en) begin
            num_seg_d  = num_segments;
            stop_lvl_d = stop_lvl;
            seg_cnt_d  = '0;
            state_d    = (num_segments == 16'd0) ? DONE_TOK : LEN;
         end
         LEN: if (bus.word_in_valid) begin
            elem_rem_d = 16'(word);
            state_d    = (word == '0) ? STOP : DATA;
         end
         DATA: if (bus.word_in_valid && slot_free) begin
            load       = 1'b1;
            load_data  = TOKEN_W'(word);
            elem_rem_d = elem_rem_q - 16'd1;
            if (elem_rem_q == 16'd1) state_d = STOP;
         end
         STOP: if (slot_free) begin
            load      = 1'b1;
            load_data = TOKEN_W'(stop_token(stop_lvl_q));
            seg_cnt_d = seg_cnt_q + 16'd1;
            state_d   = (seg_cnt_q + 16'd1 == num_seg_q) ? DONE_TOK : LEN;
         end
         DONE_TOK: if (slot_free) begin
            load      = 1'b1;
            load_data = TOKEN_W'(DONE_TOKEN);
            state_d   = FINISH;
         end
         // The slot still holds DONE here; done rises on its acceptance.
         FINISH: if (tok_valid && bus.token_out_ready) done_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state_q    <= IDLE;
         seg_cnt_q  <= '0;
         elem_rem_q <= '0;
         num_seg_q  <= '0;
         stop_lvl_q <= '0;
         done_q     <= 1'b0;
      end else if (clk_en) begin
         state_q    <= state_d;
         seg_cnt_q  <= seg_cnt_d;
         elem_rem_q <= elem_rem_d;
         num_seg_q  <= num_seg_d;
         stop_lvl_q <= stop_lvl_d;
         done_q     <= done_d;
      end
   end

   stream_out_reg #(.WIDTH(TOKEN_W)) u_out (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .clk_en_i   (clk_en),
      .load_i     (load),
      .data_i     (load_data),
      .ready_i    (bus.token_out_ready),
      .data_o     (bus.token_out),
      .valid_o    (tok_valid),
      .slot_free_o(slot_free)
   );

   assign bus.token_out_valid = tok_valid;
   assign bus.word_in_ready   = clk_en &
                                ((state_q == LEN) || ((state_q == DATA) && slot_free));
   assign done                = done_q;

endmodule

// File: tb/tb_seg_stream_tx.sv
// Randomized scoreboard bench for seg_stream_tx: a segment-list model queues the
// expected tokens, a driver feeds words, a monitor checks every accepted token.
module tb_seg_stream_tx;

   import seg_stream_tx_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, clk_en, flush, tile_en;
   logic [15:0] num_segments;
   logic [7:0]  stop_lvl;
   logic        done;

   seg_stream_tx_if #(.TOKEN_W(17), .WORD_W(16)) bus ();

   seg_stream_tx #(.TOKEN_W(17), .WORD_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .flush       (flush),
      .tile_en     (tile_en),
      .num_segments(num_segments),
      .stop_lvl    (stop_lvl),
      .done        (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] word_q[$];
   logic [16:0] exp_q[$];
   int          ready_mode = 0;   // 0: always ready, 1: 50% random, 2: never ready
   int          valid_pct  = 100;
   int          ready_hi_cnt = 0;
   bit          acc;
   bit          stall_rec = 1'b0;
   logic [16:0] stall_data;
   bit          expect_done_next = 1'b0;

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word driver: inputs change 1 time unit after the rising edge.
   initial begin
      bus.word_in         = '0;
      bus.word_in_valid   = 1'b0;
      bus.token_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         acc = bus.word_in_valid && bus.word_in_ready && rst_n && !flush;
         @(posedge clk);
         #1;
         if (acc && word_q.size() > 0) word_q.delete(0);
         if (word_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            bus.word_in_valid = 1'b1;
            bus.word_in       = word_q[0];
         end else begin
            bus.word_in_valid = 1'b0;
            bus.word_in       = 16'($urandom);
         end
         bus.token_out_ready = (ready_mode == 0) ? 1'b1 :
                               (ready_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      end
   end

   // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (bus.word_in_ready) ready_hi_cnt++;
         if (rst_n && !clk_en)
            check(!bus.token_out_valid && !bus.word_in_ready, "clk_en_gating",
                  {bus.token_out_valid, bus.word_in_ready}, 0);
         if (expect_done_next) begin
            check(done === 1'b1, "done_after_accept", done, 1);
            expect_done_next = 1'b0;
         end
         if (stall_rec && clk_en)
            check(bus.token_out_valid && bus.token_out === stall_data, "stall_stable",
                  bus.token_out, stall_data);
         if (bus.token_out_valid && bus.token_out_ready && rst_n && !flush) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_token", bus.token_out, 0);
            end else begin
               e = exp_q.pop_front();
               check(bus.token_out === e, "token", bus.token_out, e);
               if (e == DONE_TOKEN) begin
                  check(done === 1'b0, "done_before_accept", done, 0);
                  expect_done_next = 1'b1;
               end
            end
         end
         if (rst_n && !flush && clk_en && bus.token_out_valid && !bus.token_out_ready) begin
            stall_rec  = 1'b1;
            stall_data = bus.token_out;
         end else if (!(rst_n && !flush && !clk_en)) begin
            stall_rec = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: segments expand to words in and tokens out.
   task automatic issue_run(input int lens[$], input logic [15:0] data[$],
                            input logic [7:0] lvl);
      int di = 0;
      foreach (lens[s]) begin
         word_q.push_back(16'(lens[s]));
         for (int k = 0; k < lens[s]; k++) begin
            word_q.push_back(data[di]);
            exp_q.push_back({1'b0, data[di]});
            di++;
         end
         exp_q.push_back({1'b1, 8'h00, lvl});
      end
      exp_q.push_back(17'h10100);
      num_segments = 16'(lens.size());
      stop_lvl     = lvl;
      tile_en      = 1'b1;
      tick();
      tile_en      = 1'b0;
      num_segments = 16'($urandom);
      stop_lvl     = 8'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check(done === 1'b1, "done_within_budget", done, 1);
      tick(2);
      check(exp_q.size() == 0, "tokens_drained", exp_q.size(), 0);
      check(word_q.size() == 0, "words_consumed", word_q.size(), 0);
   endtask

   task automatic restart();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check(done === 1'b0, "flush_clears_done", done, 0);
      tick();
   endtask

   initial begin
      int          lens[$];
      logic [15:0] data[$];
      int          rlens[$];
      logic [15:0] rdata[$];
      int          total;
      int          snap;
      logic [7:0]  rlvl;

      rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b0;
      num_segments = '0; stop_lvl = '0;
      tick(3);
      check(bus.token_out_valid === 1'b0, "reset_valid", bus.token_out_valid, 0);
      check(bus.token_out === 17'h0, "reset_token", bus.token_out, 0);
      check(done === 1'b0, "reset_done", done, 0);
      check(bus.word_in_ready === 1'b0, "reset_ready", bus.word_in_ready, 0);
      rst_n = 1'b1;
      tick();

      // Two segments, lengths 3 and 1, stop level 0.
      lens = '{3, 1};
      data = '{16'hA, 16'hB, 16'hC, 16'hD};
      issue_run(lens, data, 8'h00);
      wait_done(200);

      // Zero segments: only DONE, input never ready.
      restart();
      snap = ready_hi_cnt;
      lens.delete();
      data.delete();
      issue_run(lens, data, 8'h5A);
      wait_done(50);
      check(ready_hi_cnt == snap, "no_ready_zero_seg", ready_hi_cnt - snap, 0);

      // Empty segments around a short one, stop level 1.
      restart();
      lens = '{0, 2, 0};
      data = '{16'($urandom), 16'($urandom)};
      issue_run(lens, data, 8'h01);
      wait_done(200);

      // ~100-word random stream, first with ready held high.
      total = 0;
      while (total < 100) begin
         int l = $urandom_range(7);
         rlens.push_back(l);
         for (int k = 0; k < l; k++) rdata.push_back(16'($urandom));
         total += l + 1;
      end
      rlvl = 8'($urandom);
      restart();
      issue_run(rlens, rdata, rlvl);
      wait_done(1000);

      // Same stream under random backpressure and gaps, with a clk_en pause.
      restart();
      ready_mode = 1;
      valid_pct  = 70;
      issue_run(rlens, rdata, rlvl);
      tick(20);
      clk_en = 1'b0;
      tick(5);
      clk_en = 1'b1;
      wait_done(3000);

      // Flush with a full slot stalled in DATA.
      restart();
      ready_mode = 2;
      valid_pct  = 100;
      lens = '{5};
      data = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      issue_run(lens, data, 8'h33);
      tick(6);
      check(bus.token_out_valid === 1'b1, "slot_full_before_flush", bus.token_out_valid, 1);
      flush = 1'b1;
      exp_q.delete();
      word_q.delete();
      tick();
      flush = 1'b0;
      check(bus.token_out_valid === 1'b0, "flush_valid", bus.token_out_valid, 0);
      check(bus.word_in_ready === 1'b0, "flush_idle_ready", bus.word_in_ready, 0);
      check(done === 1'b0, "flush_done", done, 0);
      ready_mode = 0;
      tick();
      issue_run(lens, data, 8'h33);
      wait_done(200);

      // Reset in the middle of a random run, then a clean rerun.
      restart();
      ready_mode = 1;
      issue_run(rlens, rdata, rlvl);
      tick(15);
      rst_n = 1'b0;
      exp_q.delete();
      word_q.delete();
      tick();
      check(bus.token_out_valid === 1'b0, "midrst_valid", bus.token_out_valid, 0);
      check(bus.token_out === 17'h0, "midrst_token", bus.token_out, 0);
      check(done === 1'b0, "midrst_done", done, 0);
      rst_n = 1'b1;
      tick();
      issue_run(rlens, rdata, rlvl);
      wait_done(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
